mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the data_ram256x8 interface. Sits in the MEM stage between the EX/MEM
//  pipeline register and data memory. Accepts one load/store request at a time and sequences
//  Enable/ReadWrite/Address/Size onto the RAM port. Returns read data, zero- or sign-extended,
//  plus a one-cycle completion pulse. Flags misaligned, out-of-range and illegal-size requests
//  without touching the RAM.
// PARAMETERS
//  ACCESS_CYCLES  1    cycles ram_enable stays high per access (legal range 1..15)
//  ADDR_LIMIT     256  first illegal byte address; the whole access must lie below it
// PORTS
//  clk         in   1   clock, rising edge
//  reset_n     in   1   asynchronous reset, active-low
//  req_valid   in   1   request present
//  req_ready   out  1   unit idle; request accepted when req_valid & req_ready at posedge
//  req_rw      in   1   1 = store (write), 0 = load (read); same polarity as the RAM ReadWrite
//  req_size    in   2   00 byte, 01 halfword, 10 word, 11 illegal
//  req_signed  in   1   sign-extend load data (honoured only with SIGN_EXT_EN)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; RAM uses low bits for byte/halfword
//  rsp_valid   out  1   one-cycle completion pulse
//  rsp_err     out  1   qualifies rsp_valid; 1 = request rejected, no RAM access made
//  rsp_rdata   out  32  load result, valid with rsp_valid when req_rw=0 and rsp_err=0; else 0
//  ram_enable  out  1   drives RAM Enable
//  ram_rw      out  1   drives RAM ReadWrite
//  ram_addr    out  32  drives RAM Address
//  ram_din     out  32  drives RAM DataIn
//  ram_size    out  2   drives RAM Size
//  ram_dout    in   32  RAM DataOut; byte in [7:0], halfword in [15:0], word big-endian
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, req_ready=1 after release. Reset asserted mid-access
//   drops ram_enable immediately (async); the access is abandoned and rsp_valid is not issued.
//  FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE; error path IDLE -> ERR -> IDLE.
//  IDLE: req_ready=1. On accept, latch rw, size, signed, addr, wdata and check:
//   - size 11
//   - halfword with addr[0]=1
//   - word with addr[1:0]!=0
//   - addr+bytes > ADDR_LIMIT, computed 33-bit so no wrap-around
//   Any failure -> ERR; otherwise -> SETUP.
//  SETUP (1 cycle): ram_addr/ram_rw/ram_size/ram_din driven from the latches; ram_enable=0.
//   This gives the RAM a clean 0->1 Enable edge with stable controls.
//  ACCESS (ACCESS_CYCLES cycles, down-counter): ram_enable=1; controls held stable.
//  DONE (1 cycle): ram_enable=0; rsp_valid=1, rsp_err=0.
//   Load: rsp_rdata = ram_dout sampled at the last ACCESS cycle, then extended:
//    byte uses [7:0], halfword [15:0], word passes through.
//   Store: rsp_rdata=0.
//  ERR (1 cycle): rsp_valid=1, rsp_err=1, rsp_rdata=0; RAM outputs stay 0.
//  ram_* controls hold their last value outside IDLE; cleared to 0 on return to IDLE.
//  Latency: accept edge to rsp_valid = ACCESS_CYCLES+2 cycles; error path = 1 cycle.
//   Back-to-back throughput is one request per ACCESS_CYCLES+3 cycles.
//  req_ready=0 in every state except IDLE. A request held through the busy period is taken
//   on the first IDLE edge. No response backpressure; the consumer must sample rsp_valid.
//  req_valid together with reset release: not accepted until the first edge with reset_n=1.
// CONFIGURATION
//  SIGN_EXT_EN defined: a load with req_signed=1 and size byte/halfword replicates bit 7/15
//   into the upper bits.
//  SIGN_EXT_EN undefined: loads are always zero-extended; req_signed is ignored.
// TESTING
//  1. Word store 0xDEADBEEF @0x10, then word load @0x10 (ACCESS_CYCLES=1).
//     Expect ram_enable high 1 cycle each, rsp_valid 3 cycles after accept, rdata=0xDEADBEEF.
//  2. Byte store 0x000000F0 @0x21, then signed byte load @0x21.
//     Expect rdata=0xFFFFFFF0 with SIGN_EXT_EN, 0x000000F0 without.
//  3. Halfword load @0x03, word load @0x06, size=11, word load @0xFC, word load @0xFE.
//     Expect @0x03/@0x06/size=11/@0xFE: rsp_err=1 next cycle, ram_enable never rises.
//     Expect @0xFC: legal, rsp_err=0.
//  4. req_valid held high with two queued requests.
//     Expect req_ready low during SETUP/ACCESS/DONE, second accept on the IDLE edge,
//     ACCESS_CYCLES=3 gives rsp_valid 5 cycles after each accept.
//  5. Drop reset_n during ACCESS of a store.
//     Expect ram_enable=0 and all outputs 0 asynchronously, no rsp_valid,
//     req_ready=1 after release.
//  6. Load @0x40 after preloading 0x11223344.
//     Expect ram_addr/ram_size/ram_rw stable from SETUP through ACCESS, rdata=0x11223344.

Source files
------------

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit_if
//  Purpose  : Bundles the request/response handshake and the data_ram256x8
//             port of the MEM-stage access unit.
//  Modports : slave  - the mem_access_unit itself (takes requests, drives
//                      responses and the RAM controls, reads RAM DataOut)
//             master - the pipeline side plus the RAM model (drives
//                      requests and RAM DataOut)
//  Signals  : req_valid/req_ready/req_rw/req_size/req_signed/req_addr/
//             req_wdata, rsp_valid/rsp_err/rsp_rdata,
//             ram_enable/ram_rw/ram_addr/ram_din/ram_size/ram_dout
//  Revision : 1.0  initial release
// ============================================================================
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    logic        ram_enable;
    logic        ram_rw;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [1:0]  ram_size;
    logic [31:0] ram_dout;

    modport master (
        output req_valid, req_rw, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_err, rsp_rdata,
        input  ram_enable, ram_rw, ram_addr, ram_din, ram_size,
        output ram_dout
    );

    modport slave (
        input  req_valid, req_rw, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_err, rsp_rdata,
        output ram_enable, ram_rw, ram_addr, ram_din, ram_size,
        input  ram_dout
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : MEM-stage initiator for data_ram256x8. Takes one load/store at
//             a time, sequences Enable/ReadWrite/Address/Size onto the RAM,
//             returns (optionally sign-) extended load data with a one-cycle
//             completion pulse. Misaligned, out-of-range and illegal-size
//             requests are rejected without any RAM access.
//  Ports    : clk      - clock, rising edge
//             reset_n  - asynchronous reset, active-low
//             bus      - mem_access_unit_if.slave (request, response, RAM)
//  Params   : ACCESS_CYCLES - cycles ram_enable stays high (1..15)
//             ADDR_LIMIT    - first illegal byte address
//  Macro    : SIGN_EXT_EN   - when defined, loads with req_signed=1 of byte/
//                             halfword size are sign-extended; otherwise all
//                             loads are zero-extended and req_signed ignored.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int ACCESS_CYCLES = 1,
    parameter int ADDR_LIMIT    = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_access_unit_if.slave bus
);

    localparam logic [2:0]  c_IDLE     = 3'd0;
    localparam logic [2:0]  c_SETUP    = 3'd1;
    localparam logic [2:0]  c_ACCESS   = 3'd2;
    localparam logic [2:0]  c_DONE     = 3'd3;
    localparam logic [2:0]  c_ERR      = 3'd4;
    localparam logic [3:0]  c_CNT_INIT = 4'(ACCESS_CYCLES - 1);
    localparam logic [32:0] c_LIMIT    = 33'(ADDR_LIMIT);

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_ram_enable;
    logic        r_ram_rw;
    logic [31:0] r_ram_addr;
    logic [31:0] r_ram_din;
    logic [1:0]  r_ram_size;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;
`ifdef SIGN_EXT_EN
    logic        r_signed;
`endif

    logic [32:0] w_nbytes;
    logic [32:0] w_end;
    logic        w_bad;
    logic [31:0] w_load;

    // Request legality. The end address is formed in 33 bits so a request
    // near 0xFFFFFFFF cannot wrap around and look in-range.
    always_comb begin
        w_nbytes = 33'd0;
        case (bus.req_size)
            2'b00:   w_nbytes = 33'd1;
            2'b01:   w_nbytes = 33'd2;
            2'b10:   w_nbytes = 33'd4;
            default: w_nbytes = 33'd0;
        endcase
        w_end = {1'b0, bus.req_addr} + w_nbytes;
        w_bad = (bus.req_size == 2'b11)
             || ((bus.req_size == 2'b01) && bus.req_addr[0])
             || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
             || (w_end > c_LIMIT);
    end

    // Load extension. r_ram_size still holds the access size while the
    // final ACCESS cycle samples ram_dout.
    always_comb begin
        w_load = bus.ram_dout;
        case (r_ram_size)
            2'b00: begin
                w_load = {24'd0, bus.ram_dout[7:0]};
`ifdef SIGN_EXT_EN
                if (r_signed) w_load[31:8] = {24{bus.ram_dout[7]}};
`endif
            end
            2'b01: begin
                w_load = {16'd0, bus.ram_dout[15:0]};
`ifdef SIGN_EXT_EN
                if (r_signed) w_load[31:16] = {16{bus.ram_dout[15]}};
`endif
            end
            default: w_load = bus.ram_dout;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_IDLE;
            r_cnt        <= 4'd0;
            r_ram_enable <= 1'b0;
            r_ram_rw     <= 1'b0;
            r_ram_addr   <= 32'd0;
            r_ram_din    <= 32'd0;
            r_ram_size   <= 2'b00;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= 32'd0;
`ifdef SIGN_EXT_EN
            r_signed     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.req_valid) begin
                        if (w_bad) begin
                            // RAM controls stay at their cleared IDLE values.
                            r_state     <= c_ERR;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            // Controls settle one cycle before Enable rises.
                            r_state    <= c_SETUP;
                            r_ram_rw   <= bus.req_rw;
                            r_ram_addr <= bus.req_addr;
                            r_ram_din  <= bus.req_wdata;
                            r_ram_size <= bus.req_size;
`ifdef SIGN_EXT_EN
                            r_signed   <= bus.req_signed;
`endif
                        end
                    end
                end
                c_SETUP: begin
                    r_state      <= c_ACCESS;
                    r_ram_enable <= 1'b1;
                    r_cnt        <= c_CNT_INIT;
                end
                c_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= c_DONE;
                        r_ram_enable <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_rdata  <= r_ram_rw ? 32'd0 : w_load;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_DONE, c_ERR: begin
                    r_state     <= c_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'd0;
                    r_ram_rw    <= 1'b0;
                    r_ram_addr  <= 32'd0;
                    r_ram_din   <= 32'd0;
                    r_ram_size  <= 2'b00;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Gating with reset_n keeps req_ready low while reset is held, so a
    // request is only taken on an edge where reset is already released.
    assign bus.req_ready  = (r_state == c_IDLE) && reset_n;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.ram_enable = r_ram_enable;
    assign bus.ram_rw     = r_ram_rw;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_din    = r_ram_din;
    assign bus.ram_size   = r_ram_size;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit with a big-endian
//             byte RAM model and an in-order response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int AC    = 3;
    localparam int LIMIT = 256;

    logic clk;
    logic reset_n;
    int   cyc;
    int   n_checks;
    int   n_errors;

    mem_access_unit_if bus ();

    mem_access_unit #(
        .ACCESS_CYCLES (AC),
        .ADDR_LIMIT    (LIMIT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- RAM model (big-endian) ----------------
    logic [7:0]  mem [256];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [31:0] pre_word;
    wire  [7:0]  ra = bus.ram_addr[7:0];

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr]        <= pre_word[31:24];
            mem[pre_addr + 8'd1] <= pre_word[23:16];
            mem[pre_addr + 8'd2] <= pre_word[15:8];
            mem[pre_addr + 8'd3] <= pre_word[7:0];
        end else if (bus.ram_enable && bus.ram_rw) begin
            case (bus.ram_size)
                2'b00: mem[ra] <= bus.ram_din[7:0];
                2'b01: begin
                    mem[ra]        <= bus.ram_din[15:8];
                    mem[ra + 8'd1] <= bus.ram_din[7:0];
                end
                default: begin
                    mem[ra]        <= bus.ram_din[31:24];
                    mem[ra + 8'd1] <= bus.ram_din[23:16];
                    mem[ra + 8'd2] <= bus.ram_din[15:8];
                    mem[ra + 8'd3] <= bus.ram_din[7:0];
                end
            endcase
        end
    end

    // Junk in unused upper bits and outside reads exposes missing masking
    // or sampling at the wrong cycle.
    always_comb begin
        bus.ram_dout = 32'hA5A5_A5A5;
        if (bus.ram_enable && !bus.ram_rw) begin
            case (bus.ram_size)
                2'b00:   bus.ram_dout = {24'h5A5A5A, mem[ra]};
                2'b01:   bus.ram_dout = {16'h5A5A, mem[ra], mem[ra + 8'd1]};
                default: bus.ram_dout = {mem[ra], mem[ra + 8'd1], mem[ra + 8'd2], mem[ra + 8'd3]};
            endcase
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          acc;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_mem [256];

    task automatic issue(input logic rw, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, output int busy);
        exp_t        e;
        logic [32:0] nb;
        logic [7:0]  a;
        logic        sx;
        bus.req_valid  = 1'b1;
        bus.req_rw     = rw;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        busy = 0;
        @(negedge clk);
        while (!bus.req_ready && busy < 50) begin
            busy++;
            @(negedge clk);
        end
        if (!bus.req_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout addr=%h got req_ready=%b want 1", addr, bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        nb = (size == 2'd0) ? 33'd1 : (size == 2'd1) ? 33'd2 : (size == 2'd2) ? 33'd4 : 33'd0;
`ifdef SIGN_EXT_EN
        sx = sgn;
`else
        sx = 1'b0;
`endif
        a       = addr[7:0];
        e.err   = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)
               || (({1'b0, addr} + nb) > 33'(LIMIT));
        e.rdata = 32'd0;
        e.rw    = rw;
        e.size  = size;
        e.addr  = addr;
        e.wdata = wdata;
        e.acc   = cyc + 1;
        e.lat   = e.err ? 1 : AC + 2;
        if (!e.err && rw) begin
            if (size == 2'd0) ref_mem[a] = wdata[7:0];
            else if (size == 2'd1) begin
                ref_mem[a] = wdata[15:8]; ref_mem[a + 8'd1] = wdata[7:0];
            end else begin
                ref_mem[a] = wdata[31:24]; ref_mem[a + 8'd1] = wdata[23:16];
                ref_mem[a + 8'd2] = wdata[15:8]; ref_mem[a + 8'd3] = wdata[7:0];
            end
        end else if (!e.err) begin
            if (size == 2'd0)
                e.rdata = {{24{sx & ref_mem[a][7]}}, ref_mem[a]};
            else if (size == 2'd1)
                e.rdata = {{16{sx & ref_mem[a][7]}}, ref_mem[a], ref_mem[a + 8'd1]};
            else
                e.rdata = {ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3]};
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic preload_word(input logic [7:0] addr, input logic [31:0] w);
        pre_we   = 1'b1;
        pre_addr = addr;
        pre_word = w;
        ref_mem[addr] = w[31:24]; ref_mem[addr + 8'd1] = w[23:16];
        ref_mem[addr + 8'd2] = w[15:8]; ref_mem[addr + 8'd3] = w[7:0];
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout got %0d pending want 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    exp_t        m_e;
    int          m_lat;
    int          en_run;
    logic        prev_rw;
    logic [1:0]  prev_size;
    logic [31:0] prev_addr;

    always @(negedge clk) begin
        if (!reset_n) begin
            en_run = 0;
        end else begin
            if (bus.rsp_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL rsp_unexpected got err=%b rdata=%h want no response",
                             bus.rsp_err, bus.rsp_rdata);
                end else begin
                    m_e   = sb.pop_front();
                    m_lat = cyc + 1 - m_e.acc;
                    if (bus.rsp_err !== m_e.err || bus.rsp_rdata !== m_e.rdata || m_lat != m_e.lat) begin
                        n_errors++;
                        $display("FAIL rsp addr=%h got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d",
                                 m_e.addr, bus.rsp_err, bus.rsp_rdata, m_lat, m_e.err, m_e.rdata, m_e.lat);
                    end
                end
            end
            if (bus.ram_enable) begin
                n_checks++;
                if (sb.size() == 0 || sb[0].err || bus.ram_addr !== sb[0].addr || bus.ram_rw !== sb[0].rw
                    || bus.ram_size !== sb[0].size || (sb[0].rw && bus.ram_din !== sb[0].wdata)
                    || (en_run == 0 && (bus.ram_addr !== prev_addr || bus.ram_rw !== prev_rw
                                        || bus.ram_size !== prev_size))) begin
                    n_errors++;
                    $display("FAIL ram_ctrl got addr=%h rw=%b size=%b din=%h setup_addr=%h want request at queue head",
                             bus.ram_addr, bus.ram_rw, bus.ram_size, bus.ram_din, prev_addr);
                end
                en_run++;
            end else begin
                if (en_run != 0) begin
                    n_checks++;
                    if (en_run != AC) begin
                        n_errors++;
                        $display("FAIL enable_width got %0d want %0d", en_run, AC);
                    end
                end
                en_run = 0;
                if (bus.req_ready) begin
                    n_checks++;
                    if ({bus.ram_rw, bus.ram_addr, bus.ram_din, bus.ram_size} !== 67'd0) begin
                        n_errors++;
                        $display("FAIL idle_ctrl got rw=%b addr=%h din=%h size=%b want all 0",
                                 bus.ram_rw, bus.ram_addr, bus.ram_din, bus.ram_size);
                    end
                end
            end
        end
        prev_addr = bus.ram_addr;
        prev_rw   = bus.ram_rw;
        prev_size = bus.ram_size;
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.ram_enable, bus.ram_rw,
             bus.ram_addr, bus.ram_din, bus.ram_size} !== 103'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got ready=%b valid=%b en=%b addr=%h want all 0",
                     bus.req_ready, bus.rsp_valid, bus.ram_enable, bus.ram_addr);
        end
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready got %b want 1", bus.req_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_word_store_load();
        int b;
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, b);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, b);
        wait_drain();
    endtask

    task automatic test_sign_ext();
        int b;
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000F0, b);
        issue(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, b);
        issue(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, b);
        issue(1'b1, 2'd1, 1'b0, 32'h50, 32'h12348001, b);
        issue(1'b0, 2'd1, 1'b1, 32'h50, 32'h0, b);
        issue(1'b0, 2'd1, 1'b0, 32'h50, 32'h0, b);
        wait_drain();
    endtask

    task automatic test_errors();
        int b;
        preload_word(8'hFC, 32'hA1B2C3D4);
        issue(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, b);
        issue(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, b);
        issue(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, b);
        issue(1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, b);
        issue(1'b0, 2'd2, 1'b0, 32'hFE, 32'h0, b);
        issue(1'b0, 2'd1, 1'b0, 32'hFE, 32'h0, b);
        issue(1'b0, 2'd0, 1'b0, 32'hFF, 32'h0, b);
        issue(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, b);
        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h55555555, b);
        issue(1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0, b);
        issue(1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, b);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int b;
        int a1;
        issue(1'b1, 2'd2, 1'b0, 32'h30, 32'h12345678, b);
        a1 = sb[sb.size() - 1].acc;
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, b);
        n_checks++;
        if (b != AC + 2) begin
            n_errors++;
            $display("FAIL b2b_busy got %0d cycles want %0d", b, AC + 2);
        end
        n_checks++;
        if (sb[sb.size() - 1].acc - a1 != AC + 3) begin
            n_errors++;
            $display("FAIL b2b_interval got %0d want %0d", sb[sb.size() - 1].acc - a1, AC + 3);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_access();
        int b;
        issue(1'b1, 2'd2, 1'b0, 32'h80, 32'hCAFEF00D, b);
        @(posedge clk);
        #3;
        n_checks++;
        if (bus.ram_enable !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_pre_enable got %b want 1", bus.ram_enable);
        end
        reset_n = 1'b0;
        sb.delete();
        #1;
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.ram_enable, bus.ram_rw,
             bus.ram_addr, bus.ram_din, bus.ram_size} !== 103'd0) begin
            n_errors++;
            $display("FAIL abort_outputs got en=%b rw=%b addr=%h din=%h want all 0",
                     bus.ram_enable, bus.ram_rw, bus.ram_addr, bus.ram_din);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_ready got %b want 1", bus.req_ready);
        end
        @(posedge clk);
        #1;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, b);
        wait_drain();
    endtask

    task automatic test_preload_load();
        int b;
        preload_word(8'h40, 32'h11223344);
        issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, b);
        issue(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, b);
        wait_drain();
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        cyc            = 0;
        reset_n        = 1'b0;
        pre_we         = 1'b0;
        pre_addr       = 8'd0;
        pre_word       = 32'd0;
        bus.req_valid  = 1'b0;
        bus.req_rw     = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_word_store_load();
        test_sign_ext();
        test_errors();
        test_back_to_back();
        test_reset_mid_access();
        test_preload_load();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
